bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial pattern detector. It accepts DATA_W-bit words on a valid/ready handshake and emits them one bit per clock on a bit/valid pair that connects directly to the detector's serial input and qualifier. A one-word holding buffer lets the next word be accepted while the current word is shifting, so back-to-back words produce a gapless stream. It provides downstream stall and optional inter-word idle gaps.

---
 rtl/bit_serializer_pkg.sv | 39 +++
 rtl/bit_serializer_if.sv | 30 +++
 rtl/ser_word_buf.sv | 54 +++++
 rtl/bit_serializer.sv | 180 ++++++++++++++++++
 tb/tb_bit_serializer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg
//   Shared types, widths and helpers for the bit_serializer slice:
//   - state_t     : one-hot FSM states IDLE / SHIFT / GAP
//   - calc_cnt_w  : bit-counter width for a given word width
//   - calc_gap_w  : gap-counter width for a given gap length
//   - CNT_W/GAP_W : widths for the default configuration (8-bit word, no gap)
//   - out_bit_idx : sreg index that drives ser_bit for a given bit order
package bit_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_GAP   = 3'b100
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_GAP_CYCLES = 0;

  // Bit counter spans 0..data_w-1.
  function automatic int calc_cnt_w(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

  // Gap counter spans 0..gap_cycles-1; keep at least one bit so the
  // register exists even when gaps are disabled.
  function automatic int calc_gap_w(input int gap_cycles);
    return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
  endfunction

  localparam int CNT_W = calc_cnt_w(DEF_DATA_W);
  localparam int GAP_W = calc_gap_w(DEF_GAP_CYCLES);

  // The shifter always moves toward the output end, so the output tap is
  // the MSB for MSB-first order and the LSB otherwise.
  function automatic int out_bit_idx(input bit msb_first, input int data_w);
    return msb_first ? (data_w - 1) : 0;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// bit_serializer_if
//   Bundles the upstream word handshake, the serial output pair and the
//   status outputs of bit_serializer.
//   master : upstream/downstream side (drives s_data, s_valid, ser_hold)
//   slave  : the serializer (drives s_ready, ser_bit, ser_valid, busy,
//            word_done)
interface bit_serializer_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ser_hold;
  logic              ser_bit;
  logic              ser_valid;
  logic              busy;
  logic              word_done;

  modport master (
    output s_data, s_valid, ser_hold,
    input  s_ready, ser_bit, ser_valid, busy, word_done
  );

  modport slave (
    input  s_data, s_valid, ser_hold,
    output s_ready, ser_bit, ser_valid, busy, word_done
  );

endinterface

// File: rtl/ser_word_buf.sv
// ser_word_buf
//   One-entry word buffer with a full flag. Holds the next word while the
//   shifter is still busy with the current one.
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : store wr_data (sets full)
//   wr_data  : incoming word
//   take     : shifter consumes rd_data this edge (clears full unless a
//              write lands at the same edge)
//   rd_data  : stored word
//   full     : buffer holds a word
//   ready    : buffer can accept a word this edge (low during reset)
module ser_word_buf
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              take,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              ready
);

  logic [DATA_W-1:0] data_q;
  logic              full_q;

  // A write wins over a take at the same edge: the new word becomes the
  // buffered word and the flag stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else if (wr_en) begin
      full_q <= 1'b1;
    end else if (take) begin
      full_q <= 1'b0;
    end
  end

  // NOTE: the data register is deliberately not reset; it is only read
  // while full_q is set, and full_q is always written together with it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q <= wr_data;
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;
  assign ready   = !rst && !full_q;

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial front end for the serial pattern detector. Accepts
//   DATA_W-bit words on a valid/ready handshake and emits one bit per clock
//   on ser_bit/ser_valid. A one-word buffer allows the next word to be
//   accepted while the current one shifts, so back-to-back words stream
//   without gaps; GAP_CYCLES idle cycles can be inserted after each word.
//   Parameters:
//     DATA_W     : word width (>= 2)
//     MSB_FIRST  : 1 = bit DATA_W-1 leaves first, 0 = bit 0 leaves first
//     GAP_CYCLES : idle cycles after each word (0 = none)
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     bus.s_data/s_valid/s_ready : upstream word handshake
//     bus.ser_hold               : downstream stall
//     bus.ser_bit/ser_valid      : serial output to the detector
//     bus.busy                   : shifting, in a gap, or buffer occupied
//     bus.word_done              : one-cycle pulse after a word's last bit
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  bit_serializer_if.slave     bus
);

  localparam int BCNT_W = calc_cnt_w(DATA_W);
  localparam int GCNT_W = calc_gap_w(GAP_CYCLES);
  localparam int OUT_IDX = out_bit_idx(MSB_FIRST, DATA_W);

  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST =
    GCNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_t              state_q;
  logic [DATA_W-1:0]   sreg;
  logic [DATA_W-1:0]   sreg_shifted;
  logic [BCNT_W-1:0]   bcnt;
  logic [GCNT_W-1:0]   gcnt;
  logic                word_done_q;

  logic [DATA_W-1:0]   buf_data;
  logic                buf_full;
  logic                buf_ready;
  logic                buf_wr;
  logic                buf_take;

  logic                xfer;
  logic                consume;
  logic                last_bit;
  logic                gap_end;
  logic                shifter_free;
  logic                load_direct;

  // ------------------------------------------------------------------
  // Control decode
  // ------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    xfer         = 1'b0;
    consume      = 1'b0;
    last_bit     = 1'b0;
    gap_end      = 1'b0;
    shifter_free = 1'b0;
    load_direct  = 1'b0;
    buf_wr       = 1'b0;
    buf_take     = 1'b0;

    xfer     = bus.s_valid && buf_ready;
    consume  = (state_q == ST_SHIFT) && !bus.ser_hold;
    last_bit = consume && (bcnt == BCNT_LAST);
    gap_end  = (GAP_CYCLES > 0) && (state_q == ST_GAP) && (gcnt == GCNT_LAST);

    shifter_free = (state_q == ST_IDLE)
                || (last_bit && (GAP_CYCLES == 0))
                || gap_end;

    // The buffer always has priority over a fresh word; a fresh word only
    // bypasses the buffer when the buffer is empty.
    buf_take    = shifter_free && buf_full;
    load_direct = shifter_free && !buf_full && xfer;
    buf_wr      = xfer && !load_direct;
  end

  // Shift toward the output tap; the vacated end fills with zero.
  always_comb begin
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[DATA_W-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg[DATA_W-1:1]};
    end
  end

  // ------------------------------------------------------------------
  // Holding buffer
  // ------------------------------------------------------------------
  ser_word_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (bus.s_data),
    .take    (buf_take),
    .rd_data (buf_data),
    .full    (buf_full),
    .ready   (buf_ready)
  );

  // ------------------------------------------------------------------
  // FSM + shifter
  // ------------------------------------------------------------------
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sreg        <= '0;
      bcnt        <= '0;
      gcnt        <= '0;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= last_bit;

      if (shifter_free) begin
        bcnt <= '0;
        if (buf_full) begin
          sreg    <= buf_data;
          state_q <= ST_SHIFT;
        end else if (xfer) begin
          sreg    <= bus.s_data;
          state_q <= ST_SHIFT;
        end else begin
          state_q <= ST_IDLE;
        end
      end else if (consume) begin
        sreg <= sreg_shifted;
        if (last_bit) begin
          // Only reachable with GAP_CYCLES > 0; otherwise the last bit
          // makes the shifter free and is handled above.
          bcnt    <= '0;
          gcnt    <= '0;
          state_q <= ST_GAP;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end else if (state_q == ST_GAP) begin
        // The gap runs on wall-clock cycles; ser_hold does not stretch it.
        gcnt <= gcnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.s_ready   = buf_ready;
  assign bus.ser_valid = consume;
  assign bus.ser_bit   = sreg[OUT_IDX];
  assign bus.busy      = (state_q != ST_IDLE) || buf_full;
  assign bus.word_done = word_done_q;

  // ------------------------------------------------------------------
  // Assertions
  // ------------------------------------------------------------------
  a_no_xfer_when_full: assert property (
    @(posedge clk) disable iff (rst)
      !(bus.s_valid && bus.s_ready && buf_full)
  );

  a_valid_only_in_shift: assert property (
    @(posedge clk) disable iff (rst)
      bus.ser_valid |-> (state_q == ST_SHIFT)
  );

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Three serializer instances share clock, reset and upstream drive:
//     sel 0 : MSB_FIRST=1, GAP_CYCLES=0
//     sel 1 : MSB_FIRST=1, GAP_CYCLES=2
//     sel 2 : MSB_FIRST=0, GAP_CYCLES=0
//   Each scenario resets all three and then observes the selected one.
//   Expected serial bits are queued when a word transfer is seen and
//   popped as the DUT presents valid bits.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] drv_data;
  logic       drv_valid;
  logic       drv_hold;

  always #5 clk = ~clk;

  bit_serializer_if #(.DATA_W(8)) bus_a ();
  bit_serializer_if #(.DATA_W(8)) bus_g ();
  bit_serializer_if #(.DATA_W(8)) bus_l ();

  assign bus_a.s_data = drv_data;  assign bus_a.s_valid = drv_valid;  assign bus_a.ser_hold = drv_hold;
  assign bus_g.s_data = drv_data;  assign bus_g.s_valid = drv_valid;  assign bus_g.ser_hold = drv_hold;
  assign bus_l.s_data = drv_data;  assign bus_l.s_valid = drv_valid;  assign bus_l.ser_hold = drv_hold;

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_g (.clk(clk), .rst(rst), .bus(bus_g));
  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  int sel;
  bit sel_msb;
  logic mon_v, mon_b, mon_r, mon_bz, mon_wd;

  always_comb begin
    mon_v  = bus_a.ser_valid;
    mon_b  = bus_a.ser_bit;
    mon_r  = bus_a.s_ready;
    mon_bz = bus_a.busy;
    mon_wd = bus_a.word_done;
    if (sel == 1) begin
      mon_v = bus_g.ser_valid; mon_b = bus_g.ser_bit; mon_r = bus_g.s_ready;
      mon_bz = bus_g.busy; mon_wd = bus_g.word_done;
    end else if (sel == 2) begin
      mon_v = bus_l.ser_valid; mon_b = bus_l.ser_bit; mon_r = bus_l.s_ready;
      mon_bz = bus_l.busy; mon_wd = bus_l.word_done;
    end
  end

  int checks   = 0;
  int failures = 0;

  logic [7:0] send_q[$];
  bit         exp_q[$];

  logic log_v[64], log_b[64], log_r[64], log_bz[64], log_wd[64];
  bit   hold_at[64], rst_at[64];

  task automatic select_dut(input int s);
    sel     = s;
    sel_msb = (s != 2);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 64; i++) begin
      log_v[i] = 1'b0; log_b[i] = 1'b0; log_r[i] = 1'b0;
      log_bz[i] = 1'b0; log_wd[i] = 1'b0;
      hold_at[i] = 1'b0; rst_at[i] = 1'b0;
    end
  endtask

  task automatic push_bits(input logic [7:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back(sel_msb ? w[7-i] : w[i]);
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic apply_reset();
    rst = 1'b1; drv_valid = 1'b0; drv_hold = 1'b0; drv_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    send_q.delete();
    clear_logs();
  endtask

  // Runs ncyc cycles from posedge+1. Cycle 0 is the cycle before the first
  // edge. Presents send_q words, logs outputs, scoreboards serial bits.
  task automatic collect(input int ncyc);
    bit took;
    bit e;
    logic [7:0] w;
    for (int c = 0; c < ncyc; c++) begin
      rst       = rst_at[c];
      drv_hold  = hold_at[c];
      drv_valid = (send_q.size() > 0);
      drv_data  = (send_q.size() > 0) ? send_q[0] : 8'h00;
      @(negedge clk);
      log_v[c] = mon_v; log_b[c] = mon_b; log_r[c] = mon_r;
      log_bz[c] = mon_bz; log_wd[c] = mon_wd;
      if (rst) begin
        exp_q.delete();
      end else if (mon_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stray_bit sel=%0d cycle=%0d got bit=%b with nothing expected", sel, c, mon_b);
        end else begin
          e = exp_q.pop_front();
          if (mon_b !== e) begin
            failures++;
            $display("FAIL serial_bit sel=%0d cycle=%0d got=%b exp=%b", sel, c, mon_b, e);
          end
        end
      end
      took = drv_valid && (mon_r === 1'b1);
      @(posedge clk);
      #1;
      if (took) begin
        w = send_q.pop_front();
        push_bits(w);
      end
    end
    drv_valid = 1'b0;
    drv_hold  = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic stats(output int nv, output int first, output int last);
    nv = 0; first = -1; last = -1;
    for (int c = 0; c < 64; c++) begin
      if (log_v[c] === 1'b1) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
    end
  endtask

  task automatic wd_stats(output int nwd, output int first);
    nwd = 0; first = -1;
    for (int c = 0; c < 64; c++) begin
      if (log_wd[c] === 1'b1) begin
        nwd++;
        if (first < 0) first = c;
      end
    end
  endtask

  task automatic test_reset();
    select_dut(0);
    rst = 1'b1; drv_hold = 1'b0; drv_valid = 1'b1; drv_data = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mon_v !== 1'b0)  begin failures++; $display("FAIL reset_ser_valid got=%b exp=0", mon_v); end
    checks++; if (mon_b !== 1'b0)  begin failures++; $display("FAIL reset_ser_bit got=%b exp=0", mon_b); end
    checks++; if (mon_bz !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mon_bz); end
    checks++; if (mon_r !== 1'b0)  begin failures++; $display("FAIL reset_s_ready got=%b exp=0", mon_r); end
    checks++; if (mon_wd !== 1'b0) begin failures++; $display("FAIL reset_word_done got=%b exp=0", mon_wd); end
    @(posedge clk);
    #1 rst = 1'b0; drv_valid = 1'b0;
    @(negedge clk);
    checks++; if (mon_r !== 1'b1)  begin failures++; $display("FAIL post_reset_s_ready got=%b exp=1", mon_r); end
    checks++; if (mon_bz !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", mon_bz); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int nv, f, l, nwd, wdf, k, hit;
    logic [4:0] hist;
    select_dut(0); apply_reset();
    send_q.push_back(8'h92);
    collect(14);
    stats(nv, f, l); wd_stats(nwd, wdf);
    checks++; if (nv != 8)   begin failures++; $display("FAIL single_count got=%0d exp=8", nv); end
    checks++; if (f != 1)    begin failures++; $display("FAIL single_first got=%0d exp=1", f); end
    checks++; if (l != 8)    begin failures++; $display("FAIL single_last got=%0d exp=8", l); end
    checks++; if (nwd != 1)  begin failures++; $display("FAIL single_wd_pulses got=%0d exp=1", nwd); end
    checks++; if (wdf != 9)  begin failures++; $display("FAIL single_wd_cycle got=%0d exp=9", wdf); end
    hist = '0; k = 0; hit = -1;
    for (int c = 0; c < 64; c++) begin
      if (log_v[c] === 1'b1) begin
        k++;
        hist = {hist[3:0], log_b[c]};
        if (hist == 5'b10010 && hit < 0) hit = k;
      end
    end
    checks++; if (hit != 5) begin failures++; $display("FAIL single_detect_10010 got=%0d exp=5", hit); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int nv, f, l, nwd, wdf;
    select_dut(0); apply_reset();
    send_q.push_back(8'hA5); send_q.push_back(8'h3C);
    collect(20);
    stats(nv, f, l); wd_stats(nwd, wdf);
    checks++; if (nv != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", nv); end
    checks++; if (f != 1 || l != 16) begin failures++; $display("FAIL b2b_span got=%0d..%0d exp=1..16", f, l); end
    checks++; if (log_r[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready_c1 got=%b exp=1", log_r[1]); end
    checks++; if (log_r[2] !== 1'b0) begin failures++; $display("FAIL b2b_ready_c2 got=%b exp=0", log_r[2]); end
    checks++; if (log_r[8] !== 1'b0) begin failures++; $display("FAIL b2b_ready_c8 got=%b exp=0", log_r[8]); end
    checks++; if (log_r[9] !== 1'b1) begin failures++; $display("FAIL b2b_ready_c9 got=%b exp=1", log_r[9]); end
    checks++; if (log_bz[16] !== 1'b1) begin failures++; $display("FAIL b2b_busy_c16 got=%b exp=1", log_bz[16]); end
    checks++; if (log_bz[17] !== 1'b0) begin failures++; $display("FAIL b2b_busy_c17 got=%b exp=0", log_bz[17]); end
    checks++; if (nwd != 2) begin failures++; $display("FAIL b2b_wd_pulses got=%0d exp=2", nwd); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_hold();
    int nv, f, l, nwd, wdf, bad;
    select_dut(0); apply_reset();
    send_q.push_back(8'hF0);
    hold_at[4] = 1'b1; hold_at[5] = 1'b1; hold_at[6] = 1'b1;
    collect(16);
    stats(nv, f, l); wd_stats(nwd, wdf);
    bad = 0;
    for (int c = 4; c <= 6; c++) if (log_v[c] !== 1'b0 || log_b[c] !== 1'b1) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_stall got=%0d bad cycles exp=0", bad); end
    checks++; if (nv != 8)  begin failures++; $display("FAIL hold_count got=%0d exp=8", nv); end
    checks++; if (f != 1 || l != 11) begin failures++; $display("FAIL hold_span got=%0d..%0d exp=1..11", f, l); end
    checks++; if (wdf != 12) begin failures++; $display("FAIL hold_wd_cycle got=%0d exp=12", wdf); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL hold_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_gap();
    int nv, f, l;
    select_dut(1); apply_reset();
    send_q.push_back(8'hFF); send_q.push_back(8'h00);
    collect(24);
    stats(nv, f, l);
    checks++; if (nv != 16) begin failures++; $display("FAIL gap_count got=%0d exp=16", nv); end
    checks++; if (f != 1 || l != 18) begin failures++; $display("FAIL gap_span got=%0d..%0d exp=1..18", f, l); end
    checks++; if (log_v[8] !== 1'b1 || log_v[9] !== 1'b0 || log_v[10] !== 1'b0 || log_v[11] !== 1'b1)
      begin failures++; $display("FAIL gap_window got=%b%b%b%b exp=1001", log_v[8], log_v[9], log_v[10], log_v[11]); end
    checks++; if (log_bz[9] !== 1'b1) begin failures++; $display("FAIL gap_busy got=%b exp=1", log_bz[9]); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL gap_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_lsb_first();
    int nv, f, l;
    select_dut(2); apply_reset();
    send_q.push_back(8'h01);
    collect(12);
    stats(nv, f, l);
    checks++; if (nv != 8) begin failures++; $display("FAIL lsb_count got=%0d exp=8", nv); end
    checks++; if (log_b[1] !== 1'b1 || log_b[2] !== 1'b0) begin failures++; $display("FAIL lsb_first_bits got=%b%b exp=10", log_b[1], log_b[2]); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lsb_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_word();
    int nv, f, l;
    select_dut(0); apply_reset();
    send_q.push_back(8'hA5); send_q.push_back(8'h3C);
    rst_at[5] = 1'b1; rst_at[6] = 1'b1;
    collect(7);
    checks++; if (log_bz[4] !== 1'b1 || log_r[4] !== 1'b0) begin failures++; $display("FAIL midrst_pre got busy=%b ready=%b exp busy=1 ready=0", log_bz[4], log_r[4]); end
    checks++; if (log_v[6] !== 1'b0)  begin failures++; $display("FAIL midrst_ser_valid got=%b exp=0", log_v[6]); end
    checks++; if (log_bz[6] !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", log_bz[6]); end
    checks++; if (log_r[6] !== 1'b0)  begin failures++; $display("FAIL midrst_s_ready got=%b exp=0", log_r[6]); end
    checks++; if (log_b[6] !== 1'b0)  begin failures++; $display("FAIL midrst_ser_bit got=%b exp=0", log_b[6]); end
    clear_logs();
    exp_q.delete();
    send_q.push_back(8'h81);
    collect(14);
    stats(nv, f, l);
    checks++; if (log_r[0] !== 1'b1) begin failures++; $display("FAIL midrst_ready_after got=%b exp=1", log_r[0]); end
    checks++; if (nv != 8) begin failures++; $display("FAIL midrst_count got=%0d exp=8", nv); end
    checks++; if (f != 1 || l != 8) begin failures++; $display("FAIL midrst_span got=%0d..%0d exp=1..8", f, l); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_missing got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; drv_valid = 1'b0; drv_hold = 1'b0; drv_data = '0;
    sel = 0; sel_msb = 1'b1;
    clear_logs();
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_gap();
    test_lsb_first();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
